// File: rtl/am_pkg.sv
// am_pkg: shared message layout, opcodes and FSM state type for the AM read/write server
package am_pkg;
  localparam int SDARG_BITS = 32;
  localparam int DATA_BITS = 512;
  localparam int HEAD_BITS = 6 * SDARG_BITS;
  localparam int MSG_BITS = DATA_BITS + HEAD_BITS;
  localparam logic OP_READ = 1'b0;
  localparam logic OP_WRITE = 1'b1;
  typedef logic [SDARG_BITS-1:0] sdargT;
  typedef logic [DATA_BITS-1:0] dataT;
  typedef struct packed {
    sdargT srcid;
    sdargT dstid;
    sdargT arg0;
    sdargT arg1;
    sdargT arg2;
    sdargT arg3;
  } headT;
  typedef struct packed {
    dataT data;
    headT head;
  } msgT;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} stateT;
endpackage

// File: rtl/am_req_fifo.sv
// am_req_fifo: request FIFO with registered full/almost-full; a push on full succeeds when a pop happens in the same cycle
module am_req_fifo #(
  parameter int WIDTH = am_pkg::MSG_BITS,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             almostFull,
  output logic             drop
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count, nextCount;
  logic accept;
  assign accept = push && (!full || pop);
  assign drop = push && full && !pop;
  assign nextCount = count + CW'(accept) - CW'(pop);
  assign empty = count == '0;
  assign dout = store[rdPtr];
  // pointers, occupancy and flags reflecting occupancy after this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full <= 1'b0;
      almostFull <= 1'b0;
    end else begin
      wrPtr <= wrPtr + PW'(accept);
      rdPtr <= rdPtr + PW'(pop);
      count <= nextCount;
      full <= nextCount == CW'(DEPTH);
      almostFull <= nextCount >= CW'(DEPTH - 2);
    end
  end
  // entry storage, not reset
  always_ff @(posedge clk) begin
    if (accept) store[wrPtr] <= din;
  end
endmodule

// File: rtl/am_rw_server.sv
// am_rw_server: serialises read/write requests against a local word memory and returns echoed responses
module am_rw_server #(
  parameter int SDARG_BITS = am_pkg::SDARG_BITS,
  parameter int DATA_BITS = am_pkg::DATA_BITS,
  parameter int REQ_DEPTH = 8,
  parameter int MEM_WORDS = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tx,
  input  logic [DATA_BITS+6*SDARG_BITS-1:0] tx_msg,
  output logic                              tx_full,
  output logic                              tx_almost_full,
  output logic                              rx_empty,
  output logic [DATA_BITS+6*SDARG_BITS-1:0] rx_msg,
  input  logic                              rx_pop,
  output logic                              err_overflow
);
  import am_pkg::*;
  localparam int S = SDARG_BITS;
  localparam int HB = 6 * S;
  localparam int MW = DATA_BITS + HB;
  localparam int AW = $clog2(MEM_WORDS);
  logic [MW-1:0] head, req;
  logic [DATA_BITS-1:0] mem [MEM_WORDS];
  logic [DATA_BITS-1:0] rdData, reqData;
  logic [AW-1:0] headIdx, reqIdx;
  logic fifoEmpty, deq, drop, reqWrite;
  stateT state;
  assign headIdx = head[2*S +: AW];
  assign reqIdx = req[2*S +: AW];
  assign reqWrite = req[3*S] == OP_WRITE;
  assign reqData = req[HB +: DATA_BITS];
  assign deq = !fifoEmpty && (state == IDLE || (state == HOLD && rx_pop));
  am_req_fifo #(.WIDTH(MW), .DEPTH(REQ_DEPTH)) reqFifo (
    .clk(clk),
    .rst(rst),
    .push(tx),
    .pop(deq),
    .din(tx_msg),
    .dout(head),
    .empty(fifoEmpty),
    .full(tx_full),
    .almostFull(tx_almost_full),
    .drop(drop)
  );
  // request sequencing: dequeue, execute, hold the response until popped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req <= '0;
      rx_empty <= 1'b1;
      rx_msg <= '0;
      err_overflow <= 1'b0;
    end else begin
      err_overflow <= err_overflow | drop;
      case (state)
        IDLE: if (deq) begin
          req <= head;
          state <= EXEC;
        end
        EXEC: begin
          rx_msg <= {reqWrite ? reqData : rdData, req[4*S +: S], req[5*S +: S], req[4*S-1:0]};
          rx_empty <= 1'b0;
          state <= HOLD;
        end
        HOLD: if (rx_pop) begin
          rx_empty <= 1'b1;
          req <= deq ? head : req;
          state <= deq ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // word memory: read issued on dequeue, write committed in EXEC
  always_ff @(posedge clk) begin
    if (deq) rdData <= mem[headIdx];
    if (state == EXEC && reqWrite) mem[reqIdx] <= reqData;
  end
endmodule
